// File: rtl/bram_port_arbiter_if.sv
// Signal bundle for the shared BRAM port: CPU requester, debug requester and BRAM side.
// slave = arbiter view, master = requesters/BRAM environment view.
interface bram_port_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  cpu_req;
  logic [3:0]            cpu_we;
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic [DATA_WIDTH-1:0] cpu_wdata;
  logic                  cpu_gnt;
  logic                  cpu_rvalid;
  logic [DATA_WIDTH-1:0] cpu_rdata;

  logic                  dbg_req;
  logic                  dbg_lock;
  logic [3:0]            dbg_we;
  logic [ADDR_WIDTH-1:0] dbg_addr;
  logic [DATA_WIDTH-1:0] dbg_wdata;
  logic                  dbg_gnt;
  logic                  dbg_rvalid;
  logic [DATA_WIDTH-1:0] dbg_rdata;

  logic                  bram_en;
  logic [3:0]            bram_we;
  logic [ADDR_WIDTH-1:0] bram_addr;
  logic [DATA_WIDTH-1:0] bram_din;
  logic [DATA_WIDTH-1:0] bram_dout;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata,
    input  dbg_req, dbg_lock, dbg_we, dbg_addr, dbg_wdata,
    output dbg_gnt, dbg_rvalid, dbg_rdata,
    output bram_en, bram_we, bram_addr, bram_din,
    input  bram_dout
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata,
    output dbg_req, dbg_lock, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_gnt, dbg_rvalid, dbg_rdata,
    input  bram_en, bram_we, bram_addr, bram_din,
    output bram_dout
  );
endinterface

// File: rtl/bram_port_arbiter.sv
// Arbitrates the single BRAM port between CPU and debug engine, with debug exclusive lock.
// Optional macro ARB_RR_EN: round-robin contention in the open state instead of debug priority.
module bram_port_arbiter #(
  parameter int unsigned ADDR_WIDTH   = 16,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned RD_LATENCY   = 1,
  parameter int unsigned LOCK_TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               rst_n,
  bram_port_arbiter_if.slave bus,
  output logic               lock_err
);

  localparam int unsigned CntW = $clog2(LOCK_TIMEOUT + 1);

  typedef enum logic [0:0] {StOpen, StLocked} state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic [RD_LATENCY-1:0] tag_vld_q, tag_vld_d;
  logic [RD_LATENCY-1:0] tag_dbg_q, tag_dbg_d;

  logic                  cpu_gnt, dbg_gnt, rd_issue;
  logic                  port_en;
  logic [3:0]            port_we;
  logic [ADDR_WIDTH-1:0] port_addr;
  logic [DATA_WIDTH-1:0] port_din;

`ifdef ARB_RR_EN
  // 1: debug was granted most recently, so the CPU wins the next contention.
  logic last_dbg_q, last_dbg_d;
`endif

  always_comb begin
    cpu_gnt = 1'b0;
    dbg_gnt = 1'b0;
    if (state_q == StLocked) begin
      dbg_gnt = bus.dbg_req;
    end else if (bus.dbg_req && bus.cpu_req) begin
`ifdef ARB_RR_EN
      cpu_gnt = last_dbg_q;
      dbg_gnt = ~last_dbg_q;
`else
      dbg_gnt = 1'b1;
`endif
    end else begin
      cpu_gnt = bus.cpu_req;
      dbg_gnt = bus.dbg_req;
    end
  end

  always_comb begin
    port_en   = 1'b0;
    port_we   = 4'b0;
    port_addr = '0;
    port_din  = '0;
    if (dbg_gnt) begin
      port_en   = 1'b1;
      port_we   = bus.dbg_we;
      port_addr = bus.dbg_addr;
      port_din  = bus.dbg_wdata;
    end else if (cpu_gnt) begin
      port_en   = 1'b1;
      port_we   = bus.cpu_we;
      port_addr = bus.cpu_addr;
      port_din  = bus.cpu_wdata;
    end
  end

  assign bus.cpu_gnt   = cpu_gnt;
  assign bus.dbg_gnt   = dbg_gnt;
  assign bus.bram_en   = port_en;
  assign bus.bram_we   = port_we;
  assign bus.bram_addr = port_addr;
  assign bus.bram_din  = port_din;

  assign rd_issue = (dbg_gnt && (bus.dbg_we == 4'b0)) || (cpu_gnt && (bus.cpu_we == 4'b0));

  // Tags enter at bit 0 and leave from the top bit exactly RD_LATENCY edges later.
  always_comb begin
    tag_vld_d = RD_LATENCY'({tag_vld_q, rd_issue});
    tag_dbg_d = RD_LATENCY'({tag_dbg_q, dbg_gnt});
  end

  // Gated with rst_n so a return due in the reset cycle itself is already suppressed.
  assign bus.cpu_rvalid = rst_n & tag_vld_q[RD_LATENCY-1] & ~tag_dbg_q[RD_LATENCY-1];
  assign bus.dbg_rvalid = rst_n & tag_vld_q[RD_LATENCY-1] & tag_dbg_q[RD_LATENCY-1];
  assign bus.cpu_rdata  = bus.bram_dout;
  assign bus.dbg_rdata  = bus.bram_dout;
  assign lock_err       = err_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      StOpen: begin
        cnt_d = '0;
        if (dbg_gnt && bus.dbg_lock) begin
          state_d = StLocked;
        end
      end
      StLocked: begin
        if (!bus.dbg_lock) begin
          state_d = StOpen;
          cnt_d   = '0;
        end else if (bus.dbg_req) begin
          cnt_d = '0;
        end else if (cnt_q == CntW'(LOCK_TIMEOUT - 1)) begin
          // Debug engine went quiet while holding the lock: release and flag it.
          state_d = StOpen;
          cnt_d   = '0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: begin
        state_d = StOpen;
        cnt_d   = '0;
      end
    endcase
  end

`ifdef ARB_RR_EN
  always_comb begin
    last_dbg_d = last_dbg_q;
    if (dbg_gnt) begin
      last_dbg_d = 1'b1;
    end else if (cpu_gnt) begin
      last_dbg_d = 1'b0;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StOpen;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      tag_vld_q <= '0;
      tag_dbg_q <= '0;
`ifdef ARB_RR_EN
      last_dbg_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      tag_vld_q <= tag_vld_d;
      tag_dbg_q <= tag_dbg_d;
`ifdef ARB_RR_EN
      last_dbg_q <= last_dbg_d;
`endif
    end
  end

endmodule
